// File: rtl/network_pkg.sv
// Shared types for the spike decoder: FSM state encoding and the saturating-count helper.
package network_pkg;

   typedef enum logic [1:0] {
      DEC_IDLE   = 2'd0,
      DEC_ACCUM  = 2'd1,
      DEC_ARGMAX = 2'd2,
      DEC_DONE   = 2'd3
   } dec_state_t;

   // All-ones value for a counter of the given width (saturation ceiling).
   function automatic logic [31:0] count_max(input int unsigned width);
      return (32'd1 << width) - 32'd1;
   endfunction

endpackage

// File: rtl/spike_decoder_counter.sv
// Per-neuron saturating spike counter; clear has priority over increment.
module spike_counter
   import network_pkg::*;
#(
   parameter int COUNT_W = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               clear,
   input  logic               inc,
   output logic [COUNT_W-1:0] count
);

   localparam logic [COUNT_W-1:0] CNT_MAX = COUNT_W'(count_max(COUNT_W));

   logic [COUNT_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (inc && (count_q != CNT_MAX)) begin
         count_d = count_q + COUNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/spike_decoder.sv
// Spike-count classifier: accumulates output-layer spikes over a window, then argmax-scans one neuron per cycle.
// Optional result_tie output enabled by defining SPIKE_DECODER_TIE_FLAG_EN.
//
// state      | meaning
// DEC_IDLE   | waiting for start; counters hold last window
// DEC_ACCUM  | counting spikes, window down-counter running
// DEC_ARGMAX | scanning counters 0..N-1, then one cycle to register the result
// DEC_DONE   | result_valid high, outputs frozen until result_ready
module spike_decoder
   import network_pkg::*;
#(
   parameter int NEURON_COUNT = 10,
   parameter int COUNT_W      = 8,
   parameter int WINDOW_W     = 16
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            start,
   input  logic [WINDOW_W-1:0]             window_len,
   input  logic                            neuron_spikes [NEURON_COUNT-1:0],
   output logic                            busy,
   output logic                            result_valid,
   input  logic                            result_ready,
   output logic [$clog2(NEURON_COUNT)-1:0] class_idx,
   output logic [COUNT_W-1:0]              max_count
`ifdef SPIKE_DECODER_TIE_FLAG_EN
   ,
   output logic                            result_tie
`endif
);

   localparam int IDX_W  = $clog2(NEURON_COUNT);
   localparam int SCAN_W = $clog2(NEURON_COUNT + 1);
   localparam logic [SCAN_W-1:0] SCAN_END = SCAN_W'(NEURON_COUNT);

   dec_state_t          state_q, state_d;
   logic [WINDOW_W-1:0] remaining_q, remaining_d;
   logic [SCAN_W-1:0]   scan_q, scan_d;
   logic [COUNT_W-1:0]  run_max_q, run_max_d;
   logic [IDX_W-1:0]    run_idx_q, run_idx_d;
   logic [IDX_W-1:0]    class_idx_q, class_idx_d;
   logic [COUNT_W-1:0]  max_count_q, max_count_d;
`ifdef SPIKE_DECODER_TIE_FLAG_EN
   logic                run_tie_q, run_tie_d;
   logic                result_tie_q, result_tie_d;
`endif

   logic               clear;
   logic               accum;
   logic [COUNT_W-1:0] counts [NEURON_COUNT];
   logic [COUNT_W-1:0] scan_cnt;

   for (genvar g = 0; g < NEURON_COUNT; g++) begin : g_cnt
      spike_counter #(.COUNT_W(COUNT_W)) u_cnt (
         .clk   (clk),
         .rst_n (rst_n),
         .clear (clear),
         .inc   (accum && neuron_spikes[g]),
         .count (counts[g])
      );
   end

   // Compare-based mux keeps the end-of-scan index (== NEURON_COUNT) from reading out of range.
   always_comb begin
      scan_cnt = '0;
      for (int i = 0; i < NEURON_COUNT; i++) begin
         if (scan_q == SCAN_W'(i)) scan_cnt = counts[i];
      end
   end

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      scan_d      = scan_q;
      run_max_d   = run_max_q;
      run_idx_d   = run_idx_q;
      class_idx_d = class_idx_q;
      max_count_d = max_count_q;
`ifdef SPIKE_DECODER_TIE_FLAG_EN
      run_tie_d    = run_tie_q;
      result_tie_d = result_tie_q;
`endif
      clear = 1'b0;
      accum = 1'b0;
      case (state_q)
         DEC_IDLE: begin
            if (start) begin
               clear       = 1'b1;
               remaining_d = window_len;
               scan_d      = '0;
               state_d     = (window_len == '0) ? DEC_ARGMAX : DEC_ACCUM;
            end
         end
         DEC_ACCUM: begin
            accum       = 1'b1;
            remaining_d = remaining_q - WINDOW_W'(1);
            if (remaining_q == WINDOW_W'(1)) state_d = DEC_ARGMAX;
         end
         DEC_ARGMAX: begin
            if (scan_q == SCAN_END) begin
               class_idx_d = run_idx_q;
               max_count_d = run_max_q;
`ifdef SPIKE_DECODER_TIE_FLAG_EN
               result_tie_d = run_tie_q;
`endif
               state_d = DEC_DONE;
            end else begin
               scan_d = scan_q + SCAN_W'(1);
               // Neuron 0 seeds the running max; later neurons need a strict win.
               if (scan_q == '0) begin
                  run_max_d = scan_cnt;
                  run_idx_d = '0;
`ifdef SPIKE_DECODER_TIE_FLAG_EN
                  run_tie_d = 1'b0;
`endif
               end else if (scan_cnt > run_max_q) begin
                  run_max_d = scan_cnt;
                  run_idx_d = IDX_W'(scan_q);
`ifdef SPIKE_DECODER_TIE_FLAG_EN
                  run_tie_d = 1'b0;
`endif
               end else if (scan_cnt == run_max_q) begin
`ifdef SPIKE_DECODER_TIE_FLAG_EN
                  run_tie_d = 1'b1;
`endif
               end
            end
         end
         DEC_DONE: begin
            if (result_ready) state_d = DEC_IDLE;
         end
         default: state_d = DEC_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= DEC_IDLE;
         remaining_q <= '0;
         scan_q      <= '0;
         run_max_q   <= '0;
         run_idx_q   <= '0;
         class_idx_q <= '0;
         max_count_q <= '0;
`ifdef SPIKE_DECODER_TIE_FLAG_EN
         run_tie_q    <= 1'b0;
         result_tie_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         scan_q      <= scan_d;
         run_max_q   <= run_max_d;
         run_idx_q   <= run_idx_d;
         class_idx_q <= class_idx_d;
         max_count_q <= max_count_d;
`ifdef SPIKE_DECODER_TIE_FLAG_EN
         run_tie_q    <= run_tie_d;
         result_tie_q <= result_tie_d;
`endif
      end
   end

   assign busy         = (state_q != DEC_IDLE);
   assign result_valid = (state_q == DEC_DONE);
   assign class_idx    = class_idx_q;
   assign max_count    = max_count_q;
`ifdef SPIKE_DECODER_TIE_FLAG_EN
   assign result_tie   = result_tie_q;
`endif

endmodule

// File: tb/tb_spike_decoder.sv
// Directed bench for spike_decoder: default instance plus a COUNT_W=4 instance sharing the same stimulus.
module tb_spike_decoder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic [15:0] window_len = '0;
   logic        spikes [9:0];
   logic        result_ready = 1'b0;

   logic       busy, valid, busy4, valid4;
   logic [3:0] class_idx, class_idx4;
   logic [7:0] max_count;
   logic [3:0] max_count4;
`ifdef SPIKE_DECODER_TIE_FLAG_EN
   logic tie, tie4;
`endif

   int n_tests = 0;
   int n_fail  = 0;
   int lat;
   logic [9:0] pat [$];

   always #5 clk = ~clk;

   spike_decoder #(.NEURON_COUNT(10), .COUNT_W(8), .WINDOW_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .window_len(window_len),
      .neuron_spikes(spikes), .busy(busy), .result_valid(valid),
      .result_ready(result_ready), .class_idx(class_idx), .max_count(max_count)
`ifdef SPIKE_DECODER_TIE_FLAG_EN
      , .result_tie(tie)
`endif
   );

   spike_decoder #(.NEURON_COUNT(10), .COUNT_W(4), .WINDOW_W(16)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start), .window_len(window_len),
      .neuron_spikes(spikes), .busy(busy4), .result_valid(valid4),
      .result_ready(result_ready), .class_idx(class_idx4), .max_count(max_count4)
`ifdef SPIKE_DECODER_TIE_FLAG_EN
      , .result_tie(tie4)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic set_spikes(input logic [9:0] v);
      for (int i = 0; i < 10; i++) spikes[i] = v[i];
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Start a window, play pat[] one vector per ACCUM cycle, and count edges until result_valid.
   task automatic run_window(input int w, output int latency);
      logic [9:0] v;
      window_len = 16'(w);
      start = 1'b1;
      step();
      start = 1'b0;
      latency = 0;
      for (int k = 0; k < w; k++) begin
         v = (pat.size() > 0) ? pat.pop_front() : 10'd0;
         set_spikes(v);
         step();
         latency++;
      end
      set_spikes(10'd0);
      pat.delete();
      while (!valid && latency < 200) begin
         step();
         latency++;
      end
      if (!valid) chk("timeout_result_valid", {63'd0, valid}, 64'd1);
   endtask

   task automatic handshake();
      result_ready = 1'b1;
      step();
      result_ready = 1'b0;
      chk("handshake_busy", {63'd0, busy}, 64'd0);
      chk("handshake_valid", {63'd0, valid}, 64'd0);
   endtask

   initial begin
      set_spikes(10'd0);
      #2;
      chk("rst_busy", {63'd0, busy}, 64'd0);
      chk("rst_valid", {63'd0, valid}, 64'd0);
      chk("rst_class", {60'd0, class_idx}, 64'd0);
      chk("rst_max", {56'd0, max_count}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // First start after reset release, window 20: n3 every cycle, n7 every other cycle
      for (int k = 0; k < 20; k++) pat.push_back((10'd1 << 3) | ((k % 2 == 0) ? (10'd1 << 7) : 10'd0));
      run_window(20, lat);
      chk("t1_latency", 64'(lat), 64'd31);
      chk("t1_class", {60'd0, class_idx}, 64'd3);
      chk("t1_max", {56'd0, max_count}, 64'd20);
      chk("t1_max_c4", {60'd0, max_count4}, 64'd15);
`ifdef SPIKE_DECODER_TIE_FLAG_EN
      chk("t1_tie", {63'd0, tie}, 64'd0);
`endif
      handshake();

      // Tie: n2 cycles 0..5, n5 cycles 4..9 -> 6 each, lowest index wins
      for (int k = 0; k < 10; k++) pat.push_back(((k < 6) ? (10'd1 << 2) : 10'd0) | ((k >= 4) ? (10'd1 << 5) : 10'd0));
      run_window(10, lat);
      chk("t2_latency", 64'(lat), 64'd21);
      chk("t2_class", {60'd0, class_idx}, 64'd2);
      chk("t2_max", {56'd0, max_count}, 64'd6);
`ifdef SPIKE_DECODER_TIE_FLAG_EN
      chk("t2_tie", {63'd0, tie}, 64'd1);
`endif
      handshake();

      // Saturation: window 40, n9 every cycle
      for (int k = 0; k < 40; k++) pat.push_back(10'd1 << 9);
      run_window(40, lat);
      chk("t3_latency", 64'(lat), 64'd51);
      chk("t3_class_c4", {60'd0, class_idx4}, 64'd9);
      chk("t3_max_c4", {60'd0, max_count4}, 64'd15);
      chk("t3_class", {60'd0, class_idx}, 64'd9);
      chk("t3_max", {56'd0, max_count}, 64'd40);
      handshake();

      // Zero-length window
      run_window(0, lat);
      chk("t4_latency", 64'(lat), 64'd11);
      chk("t4_class", {60'd0, class_idx}, 64'd0);
      chk("t4_max", {56'd0, max_count}, 64'd0);
      handshake();

      // Hold in DONE with result_ready low; start pulse must be ignored
      for (int k = 0; k < 3; k++) pat.push_back(10'd1 << 8);
      run_window(3, lat);
      chk("t5_latency", 64'(lat), 64'd14);
      for (int i = 0; i < 5; i++) begin
         if (i == 1) begin
            window_len = 16'd0;
            start = 1'b1;
         end
         step();
         start = 1'b0;
         chk("t5_hold_valid", {63'd0, valid}, 64'd1);
         chk("t5_hold_class", {60'd0, class_idx}, 64'd8);
         chk("t5_hold_max", {56'd0, max_count}, 64'd3);
      end
      handshake();
      step();
      chk("t5_idle_after", {63'd0, busy}, 64'd0);

      // Reset at ACCUM cycle 8, then a fresh window
      window_len = 16'd20;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int k = 0; k < 8; k++) begin
         set_spikes(10'd1 << 1);
         step();
      end
      chk("t6_busy_pre", {63'd0, busy}, 64'd1);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_busy", {63'd0, busy}, 64'd0);
      chk("t6_rst_valid", {63'd0, valid}, 64'd0);
      chk("t6_rst_class", {60'd0, class_idx}, 64'd0);
      chk("t6_rst_max", {56'd0, max_count}, 64'd0);
      set_spikes(10'd0);
      step();
      rst_n = 1'b1;
      for (int k = 0; k < 5; k++) pat.push_back((10'd1 << 6) | ((k < 3) ? (10'd1 << 1) : 10'd0));
      run_window(5, lat);
      chk("t6_latency", 64'(lat), 64'd16);
      chk("t6_class", {60'd0, class_idx}, 64'd6);
      chk("t6_max", {56'd0, max_count}, 64'd5);
      handshake();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
